// File: rtl/fetch_queue.sv
// Instruction fetch buffer: holds fetched (pc, instr) pairs between PC/IMEM and decode.
// Latency: 1 cycle from push to out_* (0 cycles when empty with FETCH_QUEUE_BYPASS_EN defined).
// Backpressure: in_ready drops (pc_hold rises) when full; head held until out_ready.
//
// Ports: clk/reset (sync, active-high); in_valid/in_pc/in_instr/in_ready push side;
// pc_hold = !in_ready to stall the PC; flush empties the queue on redirect;
// out_valid/out_pc/out_instr/out_ready pop side; count = occupied entries.
// Optional macro FETCH_QUEUE_BYPASS_EN: combinational empty-queue bypass from in_* to out_*.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             pc_hold,
    input  logic             flush,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   DEPTH_C = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic        empty, full, push, pop, wr_en, rd_adv;
    logic [63:0] head;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == DEPTH_C);
        in_ready = !full;
        pc_hold  = full;
        push     = in_valid && !full;
`ifdef FETCH_QUEUE_BYPASS_EN
        // Empty and not flushing: the incoming pair is presented directly.
        if (empty && !flush) begin
            out_valid = in_valid;
            head      = {in_pc, in_instr};
        end else begin
            out_valid = !empty;
            head      = mem_q[rd_ptr_q];
        end
        pop    = out_valid && out_ready;
        // A bypassed pair accepted by decode never enters storage.
        wr_en  = push && !(empty && pop);
        rd_adv = pop && !empty;
`else
        out_valid = !empty;
        head      = mem_q[rd_ptr_q];
        pop       = out_valid && out_ready;
        wr_en     = push;
        rd_adv    = pop;
`endif
        out_pc    = out_valid ? head[63:32] : '0;
        out_instr = out_valid ? head[31:0]  : '0;
        count     = count_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Anything pushed or popped this cycle is squashed.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_adv) rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({wr_en, rd_adv})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en && !flush && !reset) begin
            mem_q[wr_ptr_q] <= {in_pc, in_instr};
        end
    end

endmodule
